fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//   Control FSM for the IF stage. Drives the stage's brTaken, brOffset and freeze inputs.
//   Emits pipeline flush strobes, handles boot, load-use stall, branch redirect and HALT.
//   Sits between the EX stage, the hazard unit and IFStage in the top-level pipeline.
// PARAMETERS
//   BOOT_CYCLES   4      cycles freeze is held after reset release (imem settle); >=1
//   FLUSH_CYCLES  2      cycles flushIFID is held after a taken branch; >=1
//   OFF_W         24     branch offset width (matches IF adder input)
//   HALT_OPC      4'hF   ifInstr[15:12] value that halts fetch
// PORTS
//   clk         in   1      system clock, rising edge
//   rst         in   1      asynchronous, active-low reset
//   exBrValid   in   1      EX resolved a taken branch this cycle
//   exBrOffset  in   OFF_W  byte offset for that branch
//   loadUseHaz  in   1      hazard unit requests a one-cycle stall
//   ifInstr     in   16     instruction currently output by IF
//   resume      in   1      leave HALT
//   brTaken     out  1      to IF: select brOffset instead of +4
//   brOffset    out  OFF_W  to IF: branch offset (0 when brTaken=0)
//   freeze      out  1      to IF: hold PC
//   flushIFID   out  1      clear IF/ID register (insert bubble)
//   flushIDEX   out  1      clear ID/EX register (insert bubble)
//   halted      out  1      registered; FSM is in HALT
//   stallCount  out  16     registered, saturating count of load-use stall cycles
// BEHAVIOUR
//   - States: BOOT, RUN, FLUSH, HALT. 8-bit down-counter cnt shared by BOOT and FLUSH.
//   - All outputs except halted and stallCount are Mealy (state + inputs, same cycle).
//   - rst=0 (async): state=BOOT, cnt=BOOT_CYCLES-1, stallCount=0, halted=0.
//     - Outputs during reset: freeze=1; brTaken, brOffset, both flushes = 0.
//   - BOOT: freeze=1, all inputs ignored.
//     - cnt decrements each cycle; at cnt==0 -> RUN next edge.
//     - freeze therefore drops exactly BOOT_CYCLES cycles after reset release.
//   - RUN, priority high to low:
//     1. exBrValid:
//        - brTaken=1, brOffset=exBrOffset, freeze=0, flushIFID=1, flushIDEX=1.
//        - If FLUSH_CYCLES>1: -> FLUSH with cnt=FLUSH_CYCLES-2. Otherwise stay in RUN.
//        - A concurrent loadUseHaz is dropped; the stalled instr is wrong-path.
//     2. loadUseHaz:
//        - freeze=1, flushIDEX=1, flushIFID=0.
//        - stallCount+1, saturating at 16'hFFFF.
//     3. ifInstr[15:12]==HALT_OPC: -> HALT next edge.
//        - Halt instruction still advances; freeze=0 this cycle.
//   - FLUSH: flushIFID=1, freeze=0.
//     - loadUseHaz and halt opcode are ignored (wrong-path).
//     - exBrValid: redirect exactly as in RUN; cnt reloads.
//     - Otherwise cnt decrements; at cnt==0 -> RUN.
//   - HALT: freeze=1, halted=1 (registered on entry). exBrValid and loadUseHaz ignored.
//     - resume=1 -> RUN; freeze drops the following cycle.
//     - resume outside HALT has no effect.
//   - brOffset is forced to 0 whenever brTaken=0; no X propagation to the IF adder.
//   - Reset asserted mid-FLUSH or mid-HALT behaves identically to reset from idle.
// STRUCTURE
//   - Package fetch_pkg:
//     - fetch_state_t enum {BOOT, RUN, FLUSH, HALT}.
//     - PC_W=14, INSTR_W=16, OFF_W_DEF=24, OPC_HALT=4'hF.
//   - Sub-module sat_counter #(W=16): async active-low clear, inc, saturate; used for stallCount.
//   - FSM, cnt and output decode are inline.
// TESTING
//   1. Release rst with BOOT_CYCLES=4 -> freeze=1 for 4 cycles, then 0; flushes stay 0.
//   2. RUN, exBrValid=1 with exBrOffset=24'h000010:
//      - Same cycle: brTaken=1, brOffset=0x10, flushIFID=1, flushIDEX=1.
//      - Next cycle: flushIFID=1 only, then RUN.
//   3. RUN, loadUseHaz held 3 cycles -> freeze=1 and flushIDEX=1 each cycle; stallCount=3.
//   4. exBrValid and loadUseHaz in the same cycle:
//      - brTaken=1, freeze=0, stallCount unchanged.
//   5. ifInstr=16'hF000 in RUN -> next cycle halted=1, freeze=1.
//      - exBrValid ignored while halted.
//      - resume pulse -> halted=0 and freeze=0 one cycle later.
//   6. Preload stallCount=16'hFFFE, stall 3 cycles -> stallCount=16'hFFFF.
//      - Then assert rst mid-FLUSH -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the IF-stage fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam int         PC_W      = 14;
  localparam int         INSTR_W   = 16;
  localparam int         OFF_W_DEF = 24;
  localparam logic [3:0] OPC_HALT  = 4'hF;

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Count up on inc, but stick at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Counter register; clear wins asynchronously.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage control FSM: boot hold, load-use stall, branch redirect with
// IF/ID flush window, and HALT. Redirect/stall outputs are Mealy so the IF
// stage sees them in the same cycle the EX stage / hazard unit raise them.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int         BOOT_CYCLES  = 4,
  parameter int         FLUSH_CYCLES = 2,
  parameter int         OFF_W        = OFF_W_DEF,
  parameter logic [3:0] HALT_OPC     = OPC_HALT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exBrValid,
  input  logic [OFF_W-1:0]   exBrOffset,
  input  logic               loadUseHaz,
  input  logic [INSTR_W-1:0] ifInstr,
  input  logic               resume,
  output logic               brTaken,
  output logic [OFF_W-1:0]   brOffset,
  output logic               freeze,
  output logic               flushIFID,
  output logic               flushIDEX,
  output logic               halted,
  output logic [15:0]        stallCount
);

  localparam logic [7:0] BOOT_RELOAD  = 8'(BOOT_CYCLES - 1);
  // With a single flush cycle the redirect cycle itself covers it.
  localparam logic [7:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? 8'(FLUSH_CYCLES - 2) : 8'd0;
  localparam fetch_state_t BR_NEXT    = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  fetch_state_t state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         halted_q;
  logic         stall_inc;
  logic         is_halt_opc;
  logic         unused_instr;

  assign is_halt_opc  = (ifInstr[15:12] == HALT_OPC);
  assign unused_instr = ^ifInstr[11:0];

  // Next-state and Mealy output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    brTaken   = 1'b0;
    freeze    = 1'b0;
    flushIFID = 1'b0;
    flushIDEX = 1'b0;
    stall_inc = 1'b0;
    unique case (state_q)
      BOOT: begin
        freeze = 1'b1;
        if (cnt_q == 8'd0) state_d = RUN;
        else               cnt_d   = cnt_q - 8'd1;
      end
      RUN: begin
        if (exBrValid) begin
          // Redirect beats a concurrent stall: the stalled instr is wrong-path.
          brTaken   = 1'b1;
          flushIFID = 1'b1;
          flushIDEX = 1'b1;
          state_d   = BR_NEXT;
          cnt_d     = FLUSH_RELOAD;
        end else if (loadUseHaz) begin
          freeze    = 1'b1;
          flushIDEX = 1'b1;
          stall_inc = 1'b1;
        end else if (is_halt_opc) begin
          state_d = HALT;
        end
      end
      FLUSH: begin
        flushIFID = 1'b1;
        if (exBrValid) begin
          brTaken   = 1'b1;
          flushIDEX = 1'b1;
          state_d   = BR_NEXT;
          cnt_d     = FLUSH_RELOAD;
        end else if (cnt_q == 8'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HALT: begin
        freeze = 1'b1;
        if (resume) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  // Keep the IF adder input clean when no branch is taken.
  assign brOffset = brTaken ? exBrOffset : '0;

  // State, shared down-counter and registered halted flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= BOOT;
      cnt_q    <= BOOT_RELOAD;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= (state_d == HALT);
    end
  end

  assign halted = halted_q;

  sat_counter #(.W(16)) u_stall_cnt (
    .clk   (clk),
    .clr_n (rst),
    .inc_i (stall_inc),
    .cnt_o (stallCount)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        exBrValid;
  logic [23:0] exBrOffset;
  logic        loadUseHaz;
  logic [15:0] ifInstr;
  logic        resume;
  logic        brTaken;
  logic [23:0] brOffset;
  logic        freeze;
  logic        flushIFID;
  logic        flushIDEX;
  logic        halted;
  logic [15:0] stallCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .BOOT_CYCLES (4),
    .FLUSH_CYCLES(2),
    .OFF_W       (24),
    .HALT_OPC    (4'hF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .exBrValid (exBrValid),
    .exBrOffset(exBrOffset),
    .loadUseHaz(loadUseHaz),
    .ifInstr   (ifInstr),
    .resume    (resume),
    .brTaken   (brTaken),
    .brOffset  (brOffset),
    .freeze    (freeze),
    .flushIFID (flushIFID),
    .flushIDEX (flushIDEX),
    .halted    (halted),
    .stallCount(stallCount)
  );

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pack of the five control outputs: {brTaken, freeze, flushIFID, flushIDEX, halted}.
  function automatic logic [4:0] ctl();
    return {brTaken, freeze, flushIFID, flushIDEX, halted};
  endfunction

  task automatic test_reset();
    rst = 1'b0; exBrValid = 1'b0; exBrOffset = 24'hABCDEF;
    loadUseHaz = 1'b0; ifInstr = 16'h0000; resume = 1'b0;
    #3;
    checks++; if (ctl() !== 5'b01000) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl(), 5'b01000); end
    checks++; if (brOffset !== 24'h0) begin errors++; $display("FAIL reset_broff got %h exp 0", brOffset); end
    checks++; if (stallCount !== 16'h0) begin errors++; $display("FAIL reset_stall got %h exp 0", stallCount); end
    step(); step();
    rst = 1'b1;
    // Boot: freeze held for 4 cycles, inputs ignored.
    loadUseHaz = 1'b1; exBrValid = 1'b1; ifInstr = 16'hF000;
    for (int i = 0; i < 4; i++) begin
      #3;
      checks++; if (ctl() !== 5'b01000) begin errors++; $display("FAIL boot_ctl cyc %0d got %b exp %b", i, ctl(), 5'b01000); end
      step();
    end
    loadUseHaz = 1'b0; exBrValid = 1'b0; ifInstr = 16'h0000;
    #3;
    checks++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL boot_done got %b exp %b", ctl(), 5'b00000); end
    checks++; if (stallCount !== 16'h0) begin errors++; $display("FAIL boot_stall got %h exp 0", stallCount); end
    step();
  endtask

  task automatic test_branch();
    exBrValid = 1'b1; exBrOffset = 24'h000010;
    #3;
    checks++; if (ctl() !== 5'b10110) begin errors++; $display("FAIL br_ctl got %b exp %b", ctl(), 5'b10110); end
    checks++; if (brOffset !== 24'h000010) begin errors++; $display("FAIL br_off got %h exp 000010", brOffset); end
    step();
    exBrValid = 1'b0; exBrOffset = 24'h5A5A5A;
    #3;
    checks++; if (ctl() !== 5'b00100) begin errors++; $display("FAIL flush_ctl got %b exp %b", ctl(), 5'b00100); end
    checks++; if (brOffset !== 24'h0) begin errors++; $display("FAIL flush_off got %h exp 0", brOffset); end
    step();
    #3;
    checks++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL post_flush got %b exp %b", ctl(), 5'b00000); end
    step();
  endtask

  task automatic test_stall();
    loadUseHaz = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      checks++; if (ctl() !== 5'b01010) begin errors++; $display("FAIL stall_ctl cyc %0d got %b exp %b", i, ctl(), 5'b01010); end
      step();
    end
    loadUseHaz = 1'b0;
    #3;
    checks++; if (stallCount !== 16'd3) begin errors++; $display("FAIL stall_cnt got %0d exp 3", stallCount); end
    checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL stall_release got %b exp 0", freeze); end
    step();
  endtask

  task automatic test_br_and_stall();
    exBrValid = 1'b1; loadUseHaz = 1'b1; exBrOffset = 24'h000100;
    #3;
    checks++; if (ctl() !== 5'b10110) begin errors++; $display("FAIL brstall_ctl got %b exp %b", ctl(), 5'b10110); end
    checks++; if (brOffset !== 24'h000100) begin errors++; $display("FAIL brstall_off got %h exp 000100", brOffset); end
    step();
    exBrValid = 1'b0;
    // Still in FLUSH: stall request is wrong-path and ignored.
    #3;
    checks++; if (ctl() !== 5'b00100) begin errors++; $display("FAIL brstall_flush got %b exp %b", ctl(), 5'b00100); end
    step();
    loadUseHaz = 1'b0;
    #3;
    checks++; if (stallCount !== 16'd3) begin errors++; $display("FAIL brstall_cnt got %0d exp 3", stallCount); end
    step();
  endtask

  task automatic test_halt();
    ifInstr = 16'hF000;
    #3;
    checks++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL halt_issue got %b exp %b", ctl(), 5'b00000); end
    step();
    ifInstr = 16'h0000; exBrValid = 1'b1; exBrOffset = 24'h000020;
    #3;
    checks++; if (ctl() !== 5'b01001) begin errors++; $display("FAIL halt_ctl got %b exp %b", ctl(), 5'b01001); end
    checks++; if (brOffset !== 24'h0) begin errors++; $display("FAIL halt_off got %h exp 0", brOffset); end
    step();
    exBrValid = 1'b0; resume = 1'b1;
    #3;
    checks++; if (ctl() !== 5'b01001) begin errors++; $display("FAIL halt_resume got %b exp %b", ctl(), 5'b01001); end
    step();
    resume = 1'b0;
    #3;
    checks++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL halt_exit got %b exp %b", ctl(), 5'b00000); end
    step();
    // Resume outside HALT does nothing.
    resume = 1'b1;
    #3;
    checks++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL resume_run got %b exp %b", ctl(), 5'b00000); end
    step();
    resume = 1'b0;
  endtask

  task automatic test_saturate();
    loadUseHaz = 1'b1;
    repeat (65531) step();
    #3;
    checks++; if (stallCount !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h exp FFFE", stallCount); end
    repeat (3) step();
    #3;
    checks++; if (stallCount !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp FFFF", stallCount); end
    loadUseHaz = 1'b0;
    step();
    exBrValid = 1'b1; exBrOffset = 24'h000040;
    step();
    exBrValid = 1'b0;
    #3;
    checks++; if (ctl() !== 5'b00100) begin errors++; $display("FAIL sat_flush got %b exp %b", ctl(), 5'b00100); end
    rst = 1'b0;
    #1;
    checks++; if (ctl() !== 5'b01000) begin errors++; $display("FAIL rst_flush_ctl got %b exp %b", ctl(), 5'b01000); end
    checks++; if (stallCount !== 16'h0) begin errors++; $display("FAIL rst_flush_cnt got %h exp 0", stallCount); end
    checks++; if (brOffset !== 24'h0) begin errors++; $display("FAIL rst_flush_off got %h exp 0", brOffset); end
    step();
    rst = 1'b1;
    // Boot length after mid-FLUSH reset matches a cold boot.
    for (int i = 0; i < 4; i++) begin
      #3;
      checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL reboot_freeze cyc %0d got %b exp 1", i, freeze); end
      step();
    end
    #3;
    checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL reboot_done got %b exp 0", freeze); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_stall();
    test_br_and_stall();
    test_halt();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
